// File: rtl/fmap_writeback_layer00_if.sv
// Handshake and BRAM write bus for the layer-0 feature-map writeback block.
// The producer/BRAM side (master) drives the beat stream and the write grant;
// the writeback block (slave) drives ready, the BRAM write port and status.
interface fmap_writeback_layer00_if;
    logic         iStart;
    logic         iVld;
    logic [127:0] iData;
    logic         iColEnd;
    logic         oReady;
    logic         iWrGrant;
    logic         oWe;
    logic [15:0]  oCs;
    logic [8:0]   oAddr;
    logic [127:0] oWdata;
    logic         oBusy;
    logic         oDone;
    logic         oErr;

    modport master (
        output iStart, iVld, iData, iColEnd, iWrGrant,
        input  oReady, oWe, oCs, oAddr, oWdata, oBusy, oDone, oErr
    );

    modport slave (
        input  iStart, iVld, iData, iColEnd, iWrGrant,
        output oReady, oWe, oCs, oAddr, oWdata, oBusy, oDone, oErr
    );
endinterface

// File: rtl/fmap_writeback_layer00.sv
// Layer-0 output feature-map writeback.
// Beats (one per pixel, 16 x 8-bit channels) are buffered in a small FIFO and
// written to a 16-bank activation BRAM: row r goes to bank r mod 16 at word
// (r/16)*IMG_W + col, so consecutive rows land in distinct banks for the reader.
module fmap_writeback_layer00 #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,   // active-high asynchronous reset
    fmap_writeback_layer00_if.slave    bus
);

    localparam int TOTAL  = IMG_W * IMG_H;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 16) ? $clog2(IMG_H) : 4;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL - 1);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    in_col_q, in_col_d;
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [COL_W-1:0]    wr_col_q, wr_col_d;
    logic [ROW_W-1:0]    wr_row_q, wr_row_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [15:0]         cs_q, cs_d;
    logic [8:0]          addr_q, addr_d;
    logic [127:0]        wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [127:0]        fifo_mem_q [FIFO_DEPTH];

    logic                start_s;
    logic                accept_s;
    logic                pop_s;
    logic                col_last_s;
    logic [8:0]          addr_s;

    // ready_q already implies RUN, so a handshake needs no extra state gating
    assign start_s    = (state_q == S_IDLE) && bus.iStart;
    assign accept_s   = bus.iVld && ready_q;
    assign pop_s      = (fcnt_q != {FCNT_W{1'b0}}) && bus.iWrGrant;
    assign col_last_s = (in_col_q == COL_LAST);
    assign addr_s     = 9'(32'(wr_row_q >> 3'd4) * 32'(IMG_W) + 32'(wr_col_q));

    // Frame sequencing: IDLE -> RUN -> DRAIN -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s && (in_cnt_q == CNT_LAST)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // count reaches zero only at the edge of the final pop
                if (fcnt_q == {FCNT_W{1'b0}}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Input side: column tracking, beat count and the sticky column-end error
    always_comb begin
        in_col_d = in_col_q;
        in_cnt_d = in_cnt_q;
        err_d    = err_q;
        if (start_s) begin
            in_col_d = {COL_W{1'b0}};
            in_cnt_d = {CNT_W{1'b0}};
            err_d    = 1'b0;
        end else if (accept_s) begin
            in_col_d = col_last_s ? {COL_W{1'b0}} : in_col_q + COL_W'(1);
            in_cnt_d = in_cnt_q + CNT_W'(1);
            if (bus.iColEnd != col_last_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            in_col_d = in_col_q;
            in_cnt_d = in_cnt_q;
            err_d    = err_q;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count alone
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (start_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            fcnt_d   = {FCNT_W{1'b0}};
        end else begin
            wr_ptr_d = accept_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_d = pop_s    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            case ({accept_s, pop_s})
                2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
                2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
                default: fcnt_d = fcnt_q;
            endcase
        end
    end

    // Write side: raster position of the next beat to leave the FIFO
    always_comb begin
        wr_col_d = wr_col_q;
        wr_row_d = wr_row_q;
        if (start_s) begin
            wr_col_d = {COL_W{1'b0}};
            wr_row_d = {ROW_W{1'b0}};
        end else if (pop_s) begin
            if (wr_col_q == COL_LAST) begin
                wr_col_d = {COL_W{1'b0}};
                wr_row_d = wr_row_q + ROW_W'(1);
            end else begin
                wr_col_d = wr_col_q + COL_W'(1);
                wr_row_d = wr_row_q;
            end
        end else begin
            wr_col_d = wr_col_q;
            wr_row_d = wr_row_q;
        end
    end

    // Registered outputs; ready looks at next-cycle occupancy so a full FIFO never accepts
    always_comb begin
        we_d    = pop_s;
        cs_d    = pop_s ? (16'd1 << wr_row_q[3:0]) : 16'd0;
        addr_d  = pop_s ? addr_s : addr_q;
        wdata_d = pop_s ? fifo_mem_q[rd_ptr_q] : wdata_q;
        ready_d = (state_d == S_RUN) && (fcnt_d < FCNT_FULL);
        busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);
    end

    // State and control registers
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q  <= S_IDLE;
            in_col_q <= {COL_W{1'b0}};
            in_cnt_q <= {CNT_W{1'b0}};
            wr_col_q <= {COL_W{1'b0}};
            wr_row_q <= {ROW_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            fcnt_q   <= {FCNT_W{1'b0}};
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            cs_q     <= 16'd0;
            addr_q   <= 9'd0;
            wdata_q  <= 128'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_col_q <= in_col_d;
            in_cnt_q <= in_cnt_d;
            wr_col_q <= wr_col_d;
            wr_row_q <= wr_row_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            cs_q     <= cs_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Beat storage; contents are only meaningful below the occupancy count, so no reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            fifo_mem_q[wr_ptr_q] <= bus.iData;
        end
    end

    assign bus.oReady = ready_q;
    assign bus.oWe    = we_q;
    assign bus.oCs    = cs_q;
    assign bus.oAddr  = addr_q;
    assign bus.oWdata = wdata_q;
    assign bus.oBusy  = busy_q;
    assign bus.oDone  = done_q;
    assign bus.oErr   = err_q;

endmodule

// File: tb/tb_fmap_writeback_layer00.sv
// Bench for fmap_writeback_layer00: directed frames with a write scoreboard.
// The stimulus process pushes the expected (bank select, address, data) of every
// accepted beat; a monitor on the falling edge pops and compares each BRAM write.
module tb_fmap_writeback_layer00;

    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int TOTAL = IMG_W * IMG_H;

    typedef struct packed {
        logic [15:0]  cs;
        logic [8:0]   addr;
        logic [127:0] data;
    } exp_t;

    logic clk;
    logic rst;
    fmap_writeback_layer00_if bus();

    fmap_writeback_layer00 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(4)) dut (
        .clk  (clk),
        .rstn (rst),
        .bus  (bus.slave)
    );

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           idx      = 0;
    int           salt     = 0;
    int           cyc      = 0;
    int           wcnt     = 0;
    int           done_cnt = 0;
    int           first_cyc = 0;
    int           last_cyc  = 0;
    logic         grant_seen = 1'b0;
    logic         we_prev    = 1'b0;
    logic         exp_err    = 1'b0;
    logic [15:0]  cap_cs_a, cap_cs_b;
    logic [8:0]   cap_addr_a, cap_addr_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        grant_seen <= bus.iWrGrant;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] beat_data(input int i, input int s);
        return {32'(i), ~32'(i), 32'(i * 7 + s), 32'(s)};
    endfunction

    // Reference placement: row r -> bank r mod 16, word (r/16)*IMG_W + c
    task automatic push_exp(input int i);
        exp_t e;
        int r, c;
        r = i / IMG_W;
        c = i % IMG_W;
        e.cs   = 16'd1 << (r % 16);
        e.addr = 9'((r / 16) * IMG_W + c);
        e.data = beat_data(i, salt);
        sb_q.push_back(e);
    endtask

    task automatic clear_sb();
        sb_q.delete();
        wcnt = 0;
    endtask

    // Monitor: every BRAM write is checked against the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.oWe) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("wr_cs", bus.oCs, e.cs);
                    check("wr_addr", bus.oAddr, e.addr);
                    check("wr_data", bus.oWdata, e.data);
                end
                check("wr_granted", grant_seen, 1'b1);
                if (wcnt == 17 * IMG_W + 5) begin
                    cap_cs_a = bus.oCs; cap_addr_a = bus.oAddr;
                end
                if (wcnt == TOTAL - 1) begin
                    cap_cs_b = bus.oCs; cap_addr_b = bus.oAddr;
                end
                if (wcnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                wcnt++;
            end else begin
                check("cs_idle", bus.oCs, 16'd0);
            end
            if (bus.oDone) begin
                done_cnt++;
                check("done_after_last_we", we_prev, 1'b1);
                check("done_sb_empty", sb_q.size(), 0);
                check("err_at_done", bus.oErr, exp_err);
            end
            we_prev = bus.oWe;
        end
    end

    task automatic drive_cycle(input logic vld, input logic gnt, input bit inj);
        int r, c;
        logic acc;
        r = idx / IMG_W;
        c = idx % IMG_W;
        bus.iVld     = vld;
        bus.iWrGrant = gnt;
        bus.iData    = beat_data(idx, salt);
        bus.iColEnd  = vld && ((c == IMG_W - 1) || (inj && r == 2 && c == 30));
        acc = vld && bus.oReady;
        @(posedge clk); #1;
        if (acc) begin
            push_exp(idx);
            if (inj && r == 2 && c == 30) check("err_set_on_beat", bus.oErr, 1'b1);
            idx++;
        end
    endtask

    task automatic do_start(input int s);
        clear_sb();
        idx  = 0;
        salt = s;
        bus.iVld   = 1'b0;
        bus.iStart = 1'b1;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        check("start_busy", bus.oBusy, 1'b1);
        check("start_ready", bus.oReady, 1'b1);
    endtask

    task automatic run_frame(input bit rnd, input bit inj);
        int guard;
        int d0;
        guard = 0;
        while (idx < TOTAL && guard < 20000) begin
            drive_cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1,
                        rnd ? 1'($urandom_range(0, 1)) : 1'b1, inj);
            guard++;
        end
        check("all_accepted", idx, TOTAL);
        bus.iVld    = 1'b0;
        bus.iColEnd = 1'b0;
        d0 = done_cnt;
        guard = 0;
        while (done_cnt == d0 && guard < 5000) begin
            bus.iWrGrant = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        check("done_pulses", done_cnt - d0, 1);
        check("frame_writes", wcnt, TOTAL);
        check("idle_busy", bus.oBusy, 1'b0);
        check("idle_done", bus.oDone, 1'b0);
        check("idle_ready", bus.oReady, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.oReady, 1'b0);
        check({tag, "_we"},    bus.oWe,    1'b0);
        check({tag, "_cs"},    bus.oCs,    16'd0);
        check({tag, "_addr"},  bus.oAddr,  9'd0);
        check({tag, "_wdata"}, bus.oWdata, 128'd0);
        check({tag, "_busy"},  bus.oBusy,  1'b0);
        check({tag, "_done"},  bus.oDone,  1'b0);
        check({tag, "_err"},   bus.oErr,   1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.iStart   = 1'b0;
        bus.iVld     = 1'b0;
        bus.iData    = 128'd0;
        bus.iColEnd  = 1'b0;
        bus.iWrGrant = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-frame: 37 beats in, grant withdrawn so a few are still queued
        do_start(11);
        while (idx < 37) drive_cycle(1'b1, (idx < 34) ? 1'b1 : 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        clear_sb();
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle_busy", bus.oBusy, 1'b0);
        check("midrst_idle_ready", bus.oReady, 1'b0);

        // Full frame with continuous valid and grant
        do_start(22);
        run_frame(1'b0, 1'b0);
        check("throughput_span", last_cyc - first_cyc, TOTAL - 1);
        check("r17c5_cs", cap_cs_a, 16'h0002);
        check("r17c5_addr", cap_addr_a, 9'd37);
        check("r31c31_cs", cap_cs_b, 16'h8000);
        check("r31c31_addr", cap_addr_b, 9'd63);

        // Backpressure: no grant for the first 10 cycles of RUN
        do_start(33);
        repeat (10) drive_cycle(1'b1, 1'b0, 1'b0);
        check("bp_accepted", idx, 4);
        check("bp_ready_low", bus.oReady, 1'b0);
        check("bp_no_writes", wcnt, 0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        check("bp_ready_back", bus.oReady, 1'b1);
        run_frame(1'b0, 1'b0);

        // Random valid and grant
        do_start(44);
        run_frame(1'b1, 1'b0);

        // Column-end error on row 2, column 30
        do_start(55);
        exp_err = 1'b1;
        run_frame(1'b0, 1'b1);
        check("err_held_after_done", bus.oErr, 1'b1);
        exp_err = 1'b0;
        do_start(66);
        check("err_cleared_by_start", bus.oErr, 1'b0);
        run_frame(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
